// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and bus field widths for the two-master bus arbiter
package bus_arb_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int M0 = 0;
  localparam int M1 = 1;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;
endpackage

// File: rtl/bus_wdog.sv
// bus_wdog: saturating watchdog counting unacked busy cycles
module bus_wdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bus_ack,
  output logic expired
);
  logic [CNT_W-1:0] cnt;
  assign expired = cnt == CNT_W'(TIMEOUT);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !bus_ack && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/bus_arb.sv
// bus_arb: round-robin arbiter sharing the system bus between two masters, with ack timeout
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_dout,
  output logic [DATA_W-1:0] m0_din,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_dout,
  output logic [DATA_W-1:0] m1_din,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              bus_stb,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_dout,
  input  logic [DATA_W-1:0] bus_din,
  input  logic              bus_ack,
  output logic [1:0]        gnt
);
  state_t state, state_nx;
  logic [1:0] gnt_nx;
  logic last, last_nx, g, busy, g_stb, expired, done, abort;
  logic [DATA_W-1:0] din_g;
  assign busy = state == BUSY;
  assign g = gnt[M1];
  assign g_stb = g ? m1_stb : m0_stb;
  assign abort = busy && g_stb && expired && !bus_ack;
  assign done = busy && g_stb && (bus_ack || expired);
  assign bus_stb = busy && g_stb && !abort;
  assign bus_we = busy && (g ? m1_we : m0_we);
  assign bus_addr = busy ? (g ? m1_addr : m0_addr) : '0;
  assign bus_dout = busy ? (g ? m1_dout : m0_dout) : '0;
  assign din_g = (busy && !abort) ? bus_din : '0;
  assign m0_din = gnt[M0] ? din_g : '0;
  assign m1_din = gnt[M1] ? din_g : '0;
  assign m0_ack = gnt[M0] && done;
  assign m1_ack = gnt[M1] && done;
  assign m0_err = gnt[M0] && abort;
  assign m1_err = gnt[M1] && abort;
  bus_wdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wdog (
    .clk(clk), .rst(rst), .clr(!busy), .en(busy), .bus_ack(bus_ack), .expired(expired)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      last <= 1'b1;
    end else begin
      state <= state_nx;
      gnt <= gnt_nx;
      last <= last_nx;
    end
  // On contention the master that did not win last time gets the bus
  always_comb begin
    state_nx = state;
    gnt_nx = gnt;
    last_nx = last;
    if (!busy) begin
      if (m0_stb || m1_stb) begin
        state_nx = BUSY;
        gnt_nx = (m0_stb && (!m1_stb || last)) ? 2'b01 : 2'b10;
      end
    end else if (!g_stb || bus_ack || expired) begin
      state_nx = IDLE;
      gnt_nx = '0;
      last_nx = g;
    end
  end
endmodule

// File: tb/tb_bus_arb.sv
// tb_bus_arb: directed checks of grant, round-robin, timeout, reset and stb-drop behaviour
module tb_bus_arb;
  logic clk = 0, rst = 1;
  logic m0_stb = 0, m0_we = 0, m1_stb = 0, m1_we = 0, bus_ack = 0;
  logic [21:0] m0_addr = 0, m1_addr = 0, bus_addr;
  logic [31:0] m0_dout = 0, m1_dout = 0, m0_din, m1_din, bus_dout, bus_din = 0;
  logic m0_ack, m0_err, m1_ack, m1_err, bus_stb, bus_we;
  logic [1:0] gnt;
  int n_chk = 0, n_pass = 0;
  bus_arb #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m0_din(m0_din), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dout(m1_dout),
    .m1_din(m1_din), .m1_ack(m1_ack), .m1_err(m1_err),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_dout(bus_dout),
    .bus_din(bus_din), .bus_ack(bus_ack), .gnt(gnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_stb", bus_stb, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_ack", {m0_ack, m1_ack, m0_err, m1_err}, 0);
    chk("rst_din", m0_din | m1_din, 0);
    #12 rst = 0;
    // single read
    step();
    m0_stb = 1; m0_addr = 22'h40; bus_din = 32'hDEADBEEF; #1;
    chk("rd_idle_gnt", gnt, 0);
    chk("rd_idle_din", m0_din, 0);
    step();
    chk("rd_gnt", gnt, 2'b01);
    chk("rd_stb", bus_stb, 1);
    chk("rd_addr", bus_addr, 22'h40);
    chk("rd_wait_ack", m0_ack, 0);
    step(); step(); step();
    bus_ack = 1; #1;
    chk("rd_ack", m0_ack, 1);
    chk("rd_din", m0_din, 32'hDEADBEEF);
    chk("rd_err", m0_err, 0);
    chk("rd_m1_din", m1_din, 0);
    step();
    bus_ack = 0; m0_stb = 0; #1;
    chk("rd_done_gnt", gnt, 0);
    chk("rd_done_stb", bus_stb, 0);
    // contention after reset: 0,1,0,1
    rst = 1; #1; rst = 0;
    m0_stb = 1; m1_stb = 1; m1_addr = 22'h123; m0_addr = 22'h77;
    step();
    chk("ct1_gnt", gnt, 2'b01);
    chk("ct1_addr", bus_addr, 22'h77);
    bus_ack = 1; #1;
    chk("ct1_ack", {m0_ack, m1_ack}, 2'b10);
    step();
    bus_ack = 0; #1;
    chk("ct1_turn_gnt", gnt, 0);
    chk("ct1_turn_stb", bus_stb, 0);
    step();
    chk("ct2_gnt", gnt, 2'b10);
    chk("ct2_addr", bus_addr, 22'h123);
    bus_ack = 1; #1;
    chk("ct2_ack", {m0_ack, m1_ack}, 2'b01);
    step();
    bus_ack = 0; #1;
    chk("ct2_turn_gnt", gnt, 0);
    step();
    chk("ct3_gnt", gnt, 2'b01);
    bus_ack = 1;
    step();
    bus_ack = 0; m0_stb = 0; #1;
    chk("ct3_turn_gnt", gnt, 0);
    step();
    chk("ct4_gnt", gnt, 2'b10);
    bus_ack = 1;
    step();
    bus_ack = 0; m1_stb = 0; #1;
    chk("ct4_turn_gnt", gnt, 0);
    // timeout on a write from m1
    m1_stb = 1; m1_we = 1; m1_addr = 22'h100; m1_dout = 32'h12345678; bus_din = 32'hAAAA5555;
    step();
    chk("to_gnt", gnt, 2'b10);
    chk("to_we", bus_we, 1);
    chk("to_dout", bus_dout, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      chk("to_stb_hold", bus_stb, 1);
      chk("to_no_ack", m1_ack, 0);
      step();
    end
    chk("to_abort_stb", bus_stb, 0);
    chk("to_abort_ack", m1_ack, 1);
    chk("to_abort_err", m1_err, 1);
    chk("to_abort_din", m1_din, 0);
    step();
    m1_stb = 0; m1_we = 0; #1;
    chk("to_idle_gnt", gnt, 0);
    m1_stb = 1;
    step();
    chk("to_next_gnt", gnt, 2'b10);
    bus_ack = 1; #1;
    chk("to_next_ack", m1_ack, 1);
    chk("to_next_err", m1_err, 0);
    chk("to_next_din", m1_din, 32'hAAAA5555);
    step();
    bus_ack = 0; m1_stb = 0;
    // ack exactly on the timeout boundary
    m0_stb = 1; bus_din = 32'hCAFEF00D;
    step();
    chk("bd_gnt", gnt, 2'b01);
    step(); step(); step(); step();
    bus_ack = 1; #1;
    chk("bd_ack", m0_ack, 1);
    chk("bd_err", m0_err, 0);
    chk("bd_din", m0_din, 32'hCAFEF00D);
    chk("bd_stb", bus_stb, 1);
    step();
    bus_ack = 0; m0_stb = 0; #1;
    chk("bd_idle_gnt", gnt, 0);
    // reset mid-transfer
    m1_stb = 1;
    step();
    chk("rm_gnt", gnt, 2'b10);
    chk("rm_stb", bus_stb, 1);
    #2 rst = 1; bus_ack = 1; #1;
    chk("rm_rst_gnt", gnt, 0);
    chk("rm_rst_stb", bus_stb, 0);
    chk("rm_rst_ack", m1_ack, 0);
    bus_ack = 0; m0_stb = 1; #1 rst = 0;
    step();
    chk("rm_first_gnt", gnt, 2'b01);
    bus_ack = 1;
    step();
    bus_ack = 0; m0_stb = 0; m1_stb = 0; #1;
    chk("rm_idle_gnt", gnt, 0);
    // master drops stb without ack, m1 pending
    m0_stb = 1;
    step();
    chk("dr_gnt", gnt, 2'b01);
    m1_stb = 1;
    step(); step();
    m0_stb = 0; #1;
    chk("dr_stb", bus_stb, 0);
    chk("dr_ack", {m0_ack, m0_err}, 0);
    chk("dr_hold_gnt", gnt, 2'b01);
    step();
    chk("dr_idle_gnt", gnt, 0);
    step();
    chk("dr_m1_gnt", gnt, 2'b10);
    chk("dr_m1_stb", bus_stb, 1);
    bus_ack = 1; #1;
    chk("dr_m1_ack", m1_ack, 1);
    step();
    bus_ack = 0; m1_stb = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
